// File: rtl/seg7_pkg.sv
// Seven-segment support package.
//   Glyph constants (active-high, bit order {g,f,e,d,c,b,a}), the hex/decimal
//   nibble-to-glyph decoder, and a ceil(log2) helper for sizing counters.
package seg7_pkg;

    localparam logic [6:0] SEG_DASH  = 7'b1000000;  // g only
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic logic [6:0] nibble_to_seg(input logic [3:0] n);
        logic [6:0] s;
        s = SEG_BLANK;
        case (n)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;
            4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;
            4'hF: s = 7'b1110001;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per cycle).
//   i_start : load i_bin and begin; busy rises the next cycle
//   i_bin   : unsigned binary input, 4*NUM_DIGITS bits
//   o_busy  : high for 4*NUM_DIGITS shift cycles plus one result cycle
//   o_done  : high during the result cycle (o_bcd/o_ovf are final then)
//   o_bcd   : NUM_DIGITS BCD digits, digit 0 in the low nibble
//   o_ovf   : input needed more than NUM_DIGITS decimal digits
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [4*NUM_DIGITS-1:0] i_bin,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [4*NUM_DIGITS-1:0] o_bcd,
    output logic                    o_ovf
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int CW = clog2(W + 1);

    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_sh;
    logic [W-1:0]  r_bcd;
    logic          r_ovf;
    logic [W-1:0]  w_adj;
    logic          w_last;

    // Add-3 correction on every nibble that is 5 or more before the shift.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    assign w_last = (r_cnt == CW'(W));

    // A 1 leaving the top nibble means a non-zero digit beyond NUM_DIGITS,
    // so sticky-OR it into the overflow flag instead of comparing against 10**N.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_sh   <= '0;
            r_bcd  <= '0;
            r_ovf  <= 1'b0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_sh   <= i_bin;
            r_bcd  <= '0;
            r_ovf  <= 1'b0;
        end else if (r_busy) begin
            if (w_last) begin
                r_busy <= 1'b0;
            end else begin
                r_bcd <= {w_adj[W-2:0], r_sh[W-1]};
                r_sh  <= r_sh << 1;
                r_ovf <= r_ovf | w_adj[W-1];
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_busy & w_last;
    assign o_bcd  = r_bcd;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment scanner.
//   clk, rst (async, active low)
//   value/dec_mode/lz_blank/dp_mask/blank_mask : display request, sampled once per frame
//   enable     : live; 0 darkens every digit while the scan keeps running
//   display    : segments {g,f,e,d,c,b,a}; dp : decimal point
//   digit      : one-hot (per polarity) digit select, bit 0 = rightmost
//   frame_tick : high in the cycle the scan wraps from the last digit to digit 0
//   busy       : decimal conversion in progress
module seven_segment_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int DIV_BITS       = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    dec_mode,
    input  logic                    lz_blank,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    enable,
    output logic [6:0]              display,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit,
    output logic                    frame_tick,
    output logic                    busy
);

    localparam int W     = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF   = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF  = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

    logic [DIV_BITS-1:0]   r_presc;
    logic [IDX_W-1:0]      r_idx;
    logic [W-1:0]          r_buf;
    logic                  r_ovf;
    logic                  r_sh_lz;
    logic [NUM_DIGITS-1:0] r_sh_dp;
    logic [NUM_DIGITS-1:0] r_sh_blank;
    logic [6:0]            r_display;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_digit;

    logic                  w_slot_tick;
    logic                  w_frame;
    logic                  w_cvt_done;
    logic                  w_cvt_ovf;
    logic [W-1:0]          w_bcd;
    logic [NUM_DIGITS:0]   w_lead;
    logic [3:0]            w_nib;
    logic                  w_dark;
    logic [6:0]            w_seg;
    logic [NUM_DIGITS-1:0] w_dig;
    logic                  w_dp;

    assign w_slot_tick = &r_presc;
    assign w_frame     = w_slot_tick && (r_idx == LAST_IDX);

    // The converter latches its own copy of value at the snapshot edge, so
    // the frame snapshot of value lives either in r_buf (hex) or in the converter.
    bin2bcd_seq #(.NUM_DIGITS(NUM_DIGITS)) u_bcd (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_frame & dec_mode),
        .i_bin   (value),
        .o_busy  (busy),
        .o_done  (w_cvt_done),
        .o_bcd   (w_bcd),
        .o_ovf   (w_cvt_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
            if (w_slot_tick) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end
    end

    // Snapshot and digit buffer. A conversion never overlaps a snapshot
    // because a slot is far longer than the conversion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf      <= '0;
            r_ovf      <= 1'b0;
            r_sh_lz    <= 1'b0;
            r_sh_dp    <= '0;
            r_sh_blank <= '0;
        end else if (w_frame) begin
            r_sh_lz    <= lz_blank;
            r_sh_dp    <= dp_mask;
            r_sh_blank <= blank_mask;
            if (!dec_mode) begin
                r_buf <= value;
                r_ovf <= 1'b0;
            end
        end else if (w_cvt_done) begin
            r_buf <= w_bcd;
            r_ovf <= w_cvt_ovf;
        end
    end

    // w_lead[i]: nibbles i..N-1 are all zero (leading-zero run reaches digit i).
    always_comb begin
        w_lead[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_lead[i] = w_lead[i+1] & (r_buf[4*i +: 4] == 4'd0);
        end
    end

    always_comb begin
        w_nib  = r_buf[4*r_idx +: 4];
        w_dark = !enable || r_sh_blank[r_idx] ||
                 (r_sh_lz && !r_ovf && w_lead[r_idx] && (r_idx != '0));
        w_seg  = r_ovf ? SEG_DASH : nibble_to_seg(w_nib);
        w_dig  = '0;
        w_dig[r_idx] = 1'b1;
        w_dp   = r_sh_dp[r_idx];
        if (w_dark) begin
            w_seg = SEG_BLANK;
            w_dig = '0;
            w_dp  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_display <= SEG_OFF;
            r_dp      <= DP_OFF;
            r_digit   <= DIG_OFF;
        end else begin
            r_display <= (SEG_ACTIVE_LOW != 0) ? ~w_seg : w_seg;
            r_dp      <= (SEG_ACTIVE_LOW != 0) ? ~w_dp  : w_dp;
            r_digit   <= (DIG_ACTIVE_LOW != 0) ? ~w_dig : w_dig;
        end
    end

    assign display    = r_display;
    assign dp         = r_dp;
    assign digit      = r_digit;
    assign frame_tick = w_frame;

endmodule

// File: tb/tb_seven_segment_scanner.sv
module tb_seven_segment_scanner;

    // Active-low glyphs {g,f,e,d,c,b,a}
    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                           G3 = 7'b0110000, G4 = 7'b0011001, G7 = 7'b1111000,
                           G9 = 7'b0010000, GA = 7'b0001000, GB = 7'b0000011,
                           GE = 7'b0000110, GF = 7'b0001110, GD = 7'b0111111,
                           OFF = 7'h7F;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        dec_mode, lz_blank, enable;
    logic [3:0]  dp_mask, blank_mask;
    logic [6:0]  display;
    logic        dp;
    logic [3:0]  digit;
    logic        frame_tick, busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string           name;
        logic [3:0][3:0] dig;
        logic [3:0][6:0] seg;
        logic [3:0]      dp;
    } exp_t;

    exp_t sb[$];

    seven_segment_scanner #(
        .NUM_DIGITS(4), .DIV_BITS(5), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .dec_mode(dec_mode), .lz_blank(lz_blank),
        .dp_mask(dp_mask), .blank_mask(blank_mask), .enable(enable),
        .display(display), .dp(dp), .digit(digit), .frame_tick(frame_tick), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 400);
        if (!frame_tick) begin
            checks++;
            errors++;
            $display("FAIL frame_tick timeout: got none within %0d cycles", n);
        end
    endtask

    // Expected frame from hand-written glyphs; dark digits show all off.
    task automatic push_exp(input string nm, input logic [6:0] s3, input logic [6:0] s2,
                            input logic [6:0] s1, input logic [6:0] s0,
                            input logic [3:0] dark, input logic [3:0] dpon);
        exp_t e;
        logic [3:0][6:0] s;
        s = {s3, s2, s1, s0};
        e.name = nm;
        for (int k = 0; k < 4; k++) begin
            if (dark[k]) begin
                e.dig[k] = 4'hF;
                e.seg[k] = OFF;
                e.dp[k]  = 1'b1;
            end else begin
                e.dig[k] = ~(4'b0001 << k);
                e.seg[k] = s[k];
                e.dp[k]  = ~dpon[k];
            end
        end
        sb.push_back(e);
    endtask

    // Checks the frame that starts at each frame_tick for which an expectation is queued.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_tick && sb.size() > 0) begin
                e = sb.pop_front();
                for (int k = 0; k < 4; k++) begin
                    repeat ((k == 0) ? 16 : 32) @(negedge clk);
                    chk($sformatf("%s slot%0d {digit,display,dp}", e.name, k),
                        32'({digit, display, dp}), 32'({e.dig[k], e.seg[k], e.dp[k]}));
                end
            end
        end
    endtask

    task automatic set_in(input logic dm, input logic [15:0] v, input logic lz,
                          input logic [3:0] dpm, input logic [3:0] blk, input logic en);
        dec_mode = dm; value = v; lz_blank = lz; dp_mask = dpm; blank_mask = blk; enable = en;
    endtask

    task automatic vec(input string nm, input logic dm, input logic [15:0] v, input logic lz,
                       input logic [3:0] dpm, input logic [3:0] blk, input logic en,
                       input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                       input logic [6:0] s0, input logic [3:0] dark, input logic cb);
        int n;
        set_in(dm, v, lz, dpm, blk, en);
        wait_tick();
        if (cb) chk({nm, " busy at frame_tick"}, 32'(busy), 32'd0);
        @(negedge clk);
        push_exp(nm, s3, s2, s1, s0, dark, dpm);
        if (cb) begin
            n = busy ? 1 : 0;
            for (int i = 0; i < 40 && busy; i++) begin
                @(negedge clk);
                if (busy) n++;
            end
            chk({nm, " busy length"}, 32'(n), 32'd17);
        end
        wait_tick();
        wait_tick();
    endtask

    initial begin
        rst = 1'b0;
        set_in(1'b0, 16'h0, 1'b0, 4'h0, 4'h0, 1'b1);
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        chk("reset {digit,display,dp,busy,frame_tick}",
            32'({digit, display, dp, busy, frame_tick}), 32'({4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}));
        rst = 1'b1;

        vec("hex1A2F",   1'b0, 16'h1A2F, 1'b0, 4'b0000, 4'b0000, 1'b1, G1, GA, G2, GF, 4'b0000, 1'b0);
        vec("hexmasks",  1'b0, 16'h1A2F, 1'b0, 4'b0011, 4'b0100, 1'b1, G1, GA, G2, GF, 4'b0100, 1'b0);
        vec("dec1234",   1'b1, 16'd1234, 1'b0, 4'b0000, 4'b0000, 1'b1, G1, G2, G3, G4, 4'b0000, 1'b1);
        vec("dec12345",  1'b1, 16'd12345, 1'b1, 4'b0000, 4'b0000, 1'b1, GD, GD, GD, GD, 4'b0000, 1'b0);
        vec("dec9999",   1'b1, 16'd9999, 1'b0, 4'b0000, 4'b0000, 1'b1, G9, G9, G9, G9, 4'b0000, 1'b0);
        vec("dec10000",  1'b1, 16'd10000, 1'b0, 4'b0000, 4'b0000, 1'b1, GD, GD, GD, GD, 4'b0000, 1'b0);
        vec("dec7lz",    1'b1, 16'd7, 1'b1, 4'b0010, 4'b0000, 1'b1, OFF, OFF, OFF, G7, 4'b1110, 1'b0);
        vec("dec0lz",    1'b1, 16'd0, 1'b1, 4'b0000, 4'b0000, 1'b1, OFF, OFF, OFF, G0, 4'b1110, 1'b0);
        vec("hex0040lz", 1'b0, 16'h0040, 1'b1, 4'b0000, 4'b0000, 1'b1, OFF, OFF, G4, G0, 4'b1100, 1'b0);
        vec("disabled",  1'b0, 16'h1A2F, 1'b0, 4'b1111, 4'b0000, 1'b0, G1, GA, G2, GF, 4'b1111, 1'b0);

        // Mid-frame change: old frame must stay intact, new value shows next frame.
        set_in(1'b0, 16'h1234, 1'b0, 4'b0000, 4'b0000, 1'b1);
        wait_tick();
        @(negedge clk);
        push_exp("hold1234", G1, G2, G3, G4, 4'b0000, 4'b0000);
        wait_tick();
        repeat (40) @(negedge clk);
        value = 16'hBEEF;
        push_exp("newBEEF", GB, GE, GE, GF, 4'b0000, 4'b0000);
        wait_tick();
        wait_tick();

        // Reset while busy: immediate dark outputs, conversion abandoned, buffer cleared.
        set_in(1'b1, 16'd9876, 1'b0, 4'b0000, 4'b0000, 1'b1);
        wait_tick();
        repeat (5) @(negedge clk);
        chk("busy mid-conversion", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1 chk("async reset {digit,display,dp,busy,frame_tick}",
               32'({digit, display, dp, busy, frame_tick}), 32'({4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (16) @(negedge clk);
        chk("post-reset slot0 {digit,display,dp}", 32'({digit, display, dp}), 32'({4'b1110, G0, 1'b1}));
        chk("post-reset busy", 32'(busy), 32'd0);
        repeat (32) @(negedge clk);
        chk("post-reset slot1 {digit,display,dp}", 32'({digit, display, dp}), 32'({4'b1101, G0, 1'b1}));

        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
